// File: rtl/change_dispense_ctrl.sv
// Change/refund payout sequencer: greedy 10/5 Rs coin selection, hopper handshake, tube inventory.
// Optional macro CHANGE_ACK_TIMEOUT_EN aborts a payout when the hopper fails to ack in ACK_TIMEOUT cycles.
module change_dispense_ctrl #(
  parameter int AMT_W       = 5,
  parameter int COIN_MAX    = 31,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             load_en,
  input  logic [AMT_W-1:0] coin10_add,
  input  logic [AMT_W-1:0] coin5_add,
  output logic             eject_req,
  output logic             eject_coin,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [AMT_W-1:0] coin10_cnt,
  output logic [AMT_W-1:0] coin5_cnt,
  output logic             timeout_err
);

  if (COIN_MAX > (2**AMT_W) - 1 || ACK_TIMEOUT < 1) begin : g_param_chk
    $error("change_dispense_ctrl: COIN_MAX exceeds AMT_W range or ACK_TIMEOUT < 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    WAIT_ACK = 2'd2,
    FINISH   = 2'd3
  } state_t;

  localparam logic [AMT_W-1:0] AMT_TEN  = AMT_W'(10);
  localparam logic [AMT_W-1:0] AMT_FIVE = AMT_W'(5);

  state_t           state, state_d;
  logic [AMT_W-1:0] remaining, remaining_d;
  logic [AMT_W-1:0] shortfall_d;
  logic [AMT_W-1:0] coin10_d, coin5_d;
  logic             eject_req_d, eject_coin_d, busy_d, done_d;
  logic             dec10, dec5;

  // Clamp a widened signed count into [0, COIN_MAX].
  function automatic logic [AMT_W-1:0] sat_cnt(input logic signed [AMT_W+1:0] v);
    logic signed [AMT_W+1:0] ceil_v;
    ceil_v = $signed((AMT_W+2)'(COIN_MAX));
    if (v[AMT_W+1])
      return '0;
    else if (v > ceil_v)
      return AMT_W'(COIN_MAX);
    else
      return v[AMT_W-1:0];
  endfunction

  // Refill and hopper decrement land in the same cycle; both apply before saturation.
  function automatic logic [AMT_W-1:0] next_cnt(input logic [AMT_W-1:0] cnt,
                                                input logic [AMT_W-1:0] add,
                                                input logic             ld,
                                                input logic             dec);
    logic signed [AMT_W+1:0] sum;
    sum = $signed({2'b00, cnt});
    if (ld)
      sum = sum + $signed({2'b00, add});
    if (dec)
      sum = sum - $signed((AMT_W+2)'(1));
    return sat_cnt(sum);
  endfunction

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr, tmr_d;
  logic             timeout_err_d;
`endif

  always_comb begin
    state_d      = state;
    remaining_d  = remaining;
    shortfall_d  = shortfall;
    eject_req_d  = eject_req;
    eject_coin_d = eject_coin;
    busy_d       = busy;
    done_d       = 1'b0;
    dec10        = 1'b0;
    dec5         = 1'b0;
`ifdef CHANGE_ACK_TIMEOUT_EN
    tmr_d         = tmr;
    timeout_err_d = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          remaining_d = change_amt;
          shortfall_d = '0;
          busy_d      = 1'b1;
          state_d     = SELECT;
`ifdef CHANGE_ACK_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      SELECT: begin
`ifdef CHANGE_ACK_TIMEOUT_EN
        tmr_d = '0;
`endif
        if (remaining >= AMT_TEN && coin10_cnt != '0) begin
          eject_req_d  = 1'b1;
          eject_coin_d = 1'b1;
          state_d      = WAIT_ACK;
        end else if (remaining >= AMT_FIVE && coin5_cnt != '0) begin
          eject_req_d  = 1'b1;
          eject_coin_d = 1'b0;
          state_d      = WAIT_ACK;
        end else begin
          state_d = FINISH;
        end
      end
      WAIT_ACK: begin
        if (eject_ack) begin
          eject_req_d = 1'b0;
          state_d     = SELECT;
          if (eject_coin) begin
            remaining_d = remaining - AMT_TEN;
            dec10       = 1'b1;
          end else begin
            remaining_d = remaining - AMT_FIVE;
            dec5        = 1'b1;
          end
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Unacked coin stays in the tube and its value remains unpaid.
          eject_req_d   = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
`endif
      end
      FINISH: begin
        shortfall_d = remaining;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    coin10_d = next_cnt(coin10_cnt, coin10_add, load_en, dec10);
    coin5_d  = next_cnt(coin5_cnt, coin5_add, load_en, dec5);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      shortfall  <= '0;
      eject_req  <= 1'b0;
      eject_coin <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coin10_cnt <= '0;
      coin5_cnt  <= '0;
    end else begin
      state      <= state_d;
      remaining  <= remaining_d;
      shortfall  <= shortfall_d;
      eject_req  <= eject_req_d;
      eject_coin <= eject_coin_d;
      busy       <= busy_d;
      done       <= done_d;
      coin10_cnt <= coin10_d;
      coin5_cnt  <= coin5_d;
    end
  end

`ifdef CHANGE_ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmr         <= tmr_d;
      timeout_err <= timeout_err_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomized self-checking bench for change_dispense_ctrl against a closed-form greedy payout model.
module tb_change_dispense_ctrl;
  localparam int AMT_W       = 5;
  localparam int COIN_MAX    = 31;
  localparam int ACK_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             load_en;
  logic [AMT_W-1:0] coin10_add;
  logic [AMT_W-1:0] coin5_add;
  logic             eject_req;
  logic             eject_coin;
  logic             eject_ack;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic [AMT_W-1:0] coin10_cnt;
  logic [AMT_W-1:0] coin5_cnt;
  logic             timeout_err;

  int checks   = 0;
  int failures = 0;
  int m10 = 0;
  int m5  = 0;

  always #5 clk = ~clk;

  change_dispense_ctrl #(
    .AMT_W(AMT_W), .COIN_MAX(COIN_MAX), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
    .load_en(load_en), .coin10_add(coin10_add), .coin5_add(coin5_add),
    .eject_req(eject_req), .eject_coin(eject_coin), .eject_ack(eject_ack),
    .busy(busy), .done(done), .shortfall(shortfall),
    .coin10_cnt(coin10_cnt), .coin5_cnt(coin5_cnt), .timeout_err(timeout_err)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic load(input int a10, input int a5);
    @(negedge clk);
    load_en    = 1'b1;
    coin10_add = AMT_W'(a10);
    coin5_add  = AMT_W'(a5);
    @(negedge clk);
    load_en    = 1'b0;
    coin10_add = '0;
    coin5_add  = '0;
    m10 = imin(m10 + a10, COIN_MAX);
    m5  = imin(m5 + a5, COIN_MAX);
    check("load_cnt10", int'(coin10_cnt), m10);
    check("load_cnt5", int'(coin5_cnt), m5);
  endtask

  // One payout: greedy expectation computed up front, bench plays the hopper.
  task automatic payout(input int amt, input int dly, input int ld10, input bit stray, input bit exp_to);
    int q[$];
    int n10, n5, rem, exp_short, cyc, coin, hc;
    bit first;
    n10 = imin(amt / 10, m10);
    rem = amt - 10 * n10;
    n5  = imin(rem / 5, m5);
    exp_short = rem - 5 * n5;
    for (int i = 0; i < n10; i++) q.push_back(1);
    for (int i = 0; i < n5; i++) q.push_back(0);
    @(negedge clk);
    start      = 1'b1;
    change_amt = AMT_W'(amt);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    cyc   = 0;
    first = 1'b1;
    while (!done && cyc < 300) begin
      if (eject_req) begin
        coin = int'(eject_coin);
        if (q.size() == 0) check("coin_extra", 1, 0);
        else check("coin_type", coin, q.pop_front());
        if (exp_to) begin
          hc = 1;
          while (eject_req && hc < 40) begin
            @(negedge clk);
            cyc++;
            if (eject_req) hc++;
          end
          check("to_req_len", hc, ACK_TIMEOUT);
          exp_short = amt;
          q.delete();
        end else begin
          for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0 && stray) begin
              start      = 1'b1;
              change_amt = AMT_W'(30);
            end else begin
              start = 1'b0;
            end
            check("hold_req", int'(eject_req), 1);
            check("hold_coin", int'(eject_coin), coin);
          end
          start     = 1'b0;
          eject_ack = 1'b1;
          if (first && ld10 > 0) begin
            load_en    = 1'b1;
            coin10_add = AMT_W'(ld10);
          end
          @(negedge clk);
          cyc++;
          eject_ack  = 1'b0;
          load_en    = 1'b0;
          coin10_add = '0;
          check("req_drop", int'(eject_req), 0);
          first = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      check("done_budget", 0, 1);
      return;
    end
    if (amt == 0) check("latency_amt0", cyc, 2);
    check("shortfall", int'(shortfall), exp_short);
    check("busy_fall", int'(busy), 0);
    check("coins_left", q.size(), 0);
    if (!exp_to) begin
      m10 = imin(m10 - n10 + ld10, COIN_MAX);
      m5  = m5 - n5;
    end
    check("cnt10", int'(coin10_cnt), m10);
    check("cnt5", int'(coin5_cnt), m5);
    check("timeout_err", int'(timeout_err), int'(exp_to));
    @(negedge clk);
    check("done_once", int'(done), 0);
    check("short_hold", int'(shortfall), exp_short);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_req, dn;
    reset      = 1'b0;
    start      = 1'b0;
    change_amt = '0;
    load_en    = 1'b0;
    coin10_add = '0;
    coin5_add  = '0;
    eject_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", int'(eject_req), 0);
    check("rst_coin", int'(eject_coin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_short", int'(shortfall), 0);
    check("rst_cnt10", int'(coin10_cnt), 0);
    check("rst_cnt5", int'(coin5_cnt), 0);
    check("rst_terr", int'(timeout_err), 0);
    reset = 1'b1;

    // Directed scenarios
    load(3, 2);
    payout(25, 0, 0, 1'b0, 1'b0);
    payout(10, 0, 0, 1'b0, 1'b0);
    payout(15, 0, 0, 1'b0, 1'b0);
    load(5, 5);
    payout(17, 0, 0, 1'b0, 1'b0);
    payout(20, 6, 0, 1'b1, 1'b0);
    payout(10, 0, 0, 1'b0, 1'b0);
    payout(10, 0, 2, 1'b0, 1'b0);
    load(30 - m10, 0);
    load(5, 0);
    payout(0, 0, 0, 1'b0, 1'b0);
    payout(31, 1, 0, 1'b0, 1'b0);

`ifdef CHANGE_ACK_TIMEOUT_EN
    load(2, 0);
    payout(10, 0, 0, 1'b0, 1'b1);
    payout(0, 0, 0, 1'b0, 1'b0);
`endif

    // Randomized payouts
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0)
        load(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
      payout(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a hopper handshake
    load(3, 3);
    @(negedge clk);
    start      = 1'b1;
    change_amt = AMT_W'(20);
    @(negedge clk);
    start   = 1'b0;
    got_req = 0;
    for (int i = 0; i < 10 && got_req == 0; i++) begin
      if (eject_req) got_req = 1;
      else @(negedge clk);
    end
    check("abort_req_seen", got_req, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_req", int'(eject_req), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt10", int'(coin10_cnt), 0);
    check("abort_cnt5", int'(coin5_cnt), 0);
    m10 = 0;
    m5  = 0;
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences refund and change payout for the vending machine core. Accepts a rupee amount from the vend FSM on a start pulse and drives a coin hopper one coin per handshake. Selects coins greedily from a 10 Rs tube and a 5 Rs tube, tracks tube inventory, and reports any amount it could not pay.

Parameters:
AMT_W, 5, width of amount, inventory and shortfall fields
COIN_MAX, 31, inventory saturation ceiling per tube (must be <= 2^AMT_W-1)
ACK_TIMEOUT, 15, cycles to wait for eject_ack before abort (used only with CHANGE_ACK_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to pay change_amt; sampled only in IDLE
change_amt  in  AMT_W  rupees to return
load_en  in  1  add refill counts to inventory this cycle
coin10_add  in  AMT_W  10 Rs coins added on load_en
coin5_add  in  AMT_W  5 Rs coins added on load_en
eject_req  out  1  hopper request, held until ack
eject_coin  out  1  coin type for eject_req: 1 = 10 Rs, 0 = 5 Rs
eject_ack  in  1  hopper accepted the coin
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of payout
shortfall  out  AMT_W  unpaid rupees, valid with done and held until next start
coin10_cnt  out  AMT_W  current 10 Rs inventory
coin5_cnt  out  AMT_W  current 5 Rs inventory
timeout_err  out  1  sticky abort flag (tied 0 without the macro)

Behaviour:
- Reset values: eject_req=0, eject_coin=0, busy=0, done=0, shortfall=0, coin10_cnt=0, coin5_cnt=0, timeout_err=0, state=IDLE, remaining=0.
- States: IDLE, SELECT, WAIT_ACK, FINISH.
- IDLE: on start=1, latch remaining=change_amt, clear shortfall and timeout_err, go to SELECT. busy rises on the next edge. start in any other state is ignored.
- SELECT, priority order:
  - remaining>=10 and coin10_cnt>0: eject_coin=1.
  - else remaining>=5 and coin5_cnt>0: eject_coin=0.
  - else go to FINISH.
  - When a coin is selected, assert eject_req and go to WAIT_ACK.
- WAIT_ACK: hold eject_req and eject_coin stable until eject_ack=1. On the ack edge:
  - Deassert eject_req.
  - Subtract 10 or 5 from remaining.
  - Decrement the matching inventory.
  - Return to SELECT.
  - Ack outside WAIT_ACK is ignored.
- Minimum cost per coin is 2 cycles (SELECT, then WAIT_ACK with immediate ack). change_amt=0 reaches FINISH 2 cycles after start.
- FINISH: shortfall=remaining. Pulse done for one cycle, clear busy, return to IDLE.
- An amount that is not a multiple of 5 pays the multiple-of-5 part; the residue (1..4) lands in shortfall.
- Inventory update: next count = count + (load_en ? add : 0) − (ack decrement), saturated at COIN_MAX.
  - Load and decrement in the same cycle both apply.
  - A load while busy is visible to the next SELECT.
  - A decrement at count 0 cannot occur, because SELECT checks for count>0.
- Reset mid-payout aborts immediately: all outputs return to reset values and inventory is cleared. The firmware reload path re-issues load_en.

Optional Feature:
CHANGE_ACK_TIMEOUT_EN:
- Defined: a counter runs in WAIT_ACK and is cleared on entry. If ACK_TIMEOUT cycles elapse without ack:
  - Drop eject_req.
  - Set timeout_err=1 (sticky until next start).
  - Do not decrement inventory.
  - Go to FINISH with shortfall=remaining.
- Undefined: WAIT_ACK waits indefinitely, no counter logic, timeout_err tied 0.

Test Plan:
- load_en with coin10_add=3, coin5_add=2; start with change_amt=25, ack 1 cycle after each req -> coins ejected in order 10,10,5; done with shortfall=0; coin10_cnt=1, coin5_cnt=1.
- Inventory 10 Rs=0, 5 Rs=1; change_amt=15 -> one 5 Rs coin ejected; done with shortfall=10; coin5_cnt=0.
- change_amt=17, inventory 5/5 -> coins ejected 10,5; shortfall=2.
- Ack delayed 6 cycles -> eject_req and eject_coin held stable for 6 cycles; a second start pulse while busy is ignored; exactly one done pulse.
- load_en with coin10_add=2 in the same cycle as a 10 Rs ack at coin10_cnt=1 -> coin10_cnt=2; with coin10_cnt=30 and coin10_add=5 -> saturates at 31.
- reset=0 during WAIT_ACK -> eject_req, busy and counts go to 0 asynchronously, with no done pulse. With CHANGE_ACK_TIMEOUT_EN and no ack -> eject_req drops after 15 cycles; timeout_err=1; shortfall equals the unpaid amount.
